// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_WORD_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StFill,
    StDone
  } imem_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs four accepted bytes, big-endian, into one 32-bit word.
module byte_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             in_byte,
  output logic                   word_valid,
  output logic [IMEM_WORD_W-1:0] word
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (clear) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (accept) begin
      idx_q   <= idx_q + 2'd1;
      shift_q <= {shift_q[15:0], in_byte};
    end
  end

  // Fourth byte goes straight into the word so it is usable in the accept cycle.
  assign word_valid = accept && !clear && (idx_q == 2'd3);
  assign word       = {shift_q, in_byte};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: length byte, packed words, then zero fill.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [IMEM_WORD_W-1:0] mem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned Depth = 1 << ADDR_W;

  imem_state_e state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CntW-1:0]        n_q, n_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [IMEM_WORD_W-1:0] wdata_q, wdata_d;

  logic                   accept;
  logic                   clear;
  logic                   word_valid;
  logic [IMEM_WORD_W-1:0] word;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept && (state_q == StData)),
    .in_byte    (in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  assign in_ready = (state_q == StLen) || (state_q == StData);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);
  assign cpu_hold = busy && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLen;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      StLen: begin
        if (accept) begin
          // A zero length byte means a full memory image.
          n_d     = (in_byte == 8'd0) ? CntW'(Depth) : CntW'(in_byte);
          state_d = StData;
        end
      end
      StData: begin
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = word;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q + CntW'(1) == n_q) begin
            state_d = (n_q == CntW'(Depth)) ? StDone : StFill;
          end
        end
      end
      StFill: begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_W-1:0];
        wdata_d = '0;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Depth - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
